// File: rtl/datapath_unpack_fifo_if.sv
// Signal bundle of the 192->128 unpacking FIFO: paced datapath write port,
// host-side beat stream and the memory status/error flags.
interface datapath_unpack_fifo_if #(
  parameter int INPUT_DATA_WIDTH  = 192,
  parameter int OUTPUT_DATA_WIDTH = 128,
  parameter int DEPTH_SIZE        = 10
);
  logic                         wr;
  logic [INPUT_DATA_WIDTH-1:0]  data_in;
  logic                         wr_en_100ns;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUTPUT_DATA_WIDTH-1:0] data_out;
  logic                         out_last;
  logic [DEPTH_SIZE:0]          data_count;
  logic                         full;
  logic                         empty;
  logic                         threshold;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output wr, data_in, out_ready,
    input  wr_en_100ns, out_valid, data_out, out_last,
    input  data_count, full, empty, threshold, overflow, underflow
  );

  modport slave (
    input  wr, data_in, out_ready,
    output wr_en_100ns, out_valid, data_out, out_last,
    output data_count, full, empty, threshold, overflow, underflow
  );
endinterface

// File: rtl/datapath_unpack_fifo.sv
// Egress FIFO: stores paced 192-bit datapath words and replays each one as two
// 128-bit beats (low 128 bits, then the upper 64 bits zero-extended).
module datapath_unpack_fifo #(
  parameter int INPUT_DATA_WIDTH  = 192,
  parameter int OUTPUT_DATA_WIDTH = 128,
  parameter int DEPTH             = 1024,
  parameter int DEPTH_SIZE        = 10,
  parameter int CLK_DIV           = 30
) (
  input logic                   clk,
  input logic                   rstn,
  datapath_unpack_fifo_if.slave bus
);

  localparam int         HI_WIDTH  = INPUT_DATA_WIDTH - OUTPUT_DATA_WIDTH;
  localparam int         PAD_WIDTH = OUTPUT_DATA_WIDTH - HI_WIDTH;
  localparam logic [5:0] TICK_LAST = 6'(CLK_DIV - 1);
  localparam logic       PHASE_LO  = 1'b0;
  localparam logic       PHASE_HI  = 1'b1;

  logic [5:0]                   tick_cnt_q, tick_cnt_d;
  logic [DEPTH_SIZE:0]          w_ptr_q, w_ptr_d;
  logic [DEPTH_SIZE:0]          r_ptr_q, r_ptr_d;
  logic [INPUT_DATA_WIDTH-1:0]  word_q, word_d;
  logic                         out_valid_q, out_valid_d;
  logic                         phase_q, phase_d;
  logic                         overflow_q, overflow_d;
  logic                         underflow_q, underflow_d;

  logic                         tick;
  logic                         wr_en;
  logic                         rd_en;
  logic                         handshake;
  logic                         full;
  logic                         empty;
  logic [DEPTH_SIZE:0]          count;
  logic [DEPTH_SIZE-1:0]        w_addr;
  logic [DEPTH_SIZE-1:0]        r_addr;

  logic [OUTPUT_DATA_WIDTH-1:0] mem_lo [DEPTH];
  logic [HI_WIDTH-1:0]          mem_hi [DEPTH];

  // The write side only looks at wr once every CLK_DIV cycles.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? 6'd0 : tick_cnt_q + 6'd1;

  assign w_addr = w_ptr_q[DEPTH_SIZE-1:0];
  assign r_addr = r_ptr_q[DEPTH_SIZE-1:0];
  assign empty  = (w_ptr_q == r_ptr_q);
  assign full   = (w_ptr_q[DEPTH_SIZE] != r_ptr_q[DEPTH_SIZE]) &&
                  (w_ptr_q[DEPTH_SIZE-1:0] == r_ptr_q[DEPTH_SIZE-1:0]);
  assign count  = w_ptr_q - r_ptr_q;

  assign wr_en     = bus.wr & tick & ~full;
  assign handshake = out_valid_q & bus.out_ready;
  // Reloading on the beat-1 handshake keeps the beat stream bubble-free.
  assign rd_en     = ~empty & (~out_valid_q | (bus.out_ready & phase_q));

  assign w_ptr_d = w_ptr_q + {{DEPTH_SIZE{1'b0}}, wr_en};
  assign r_ptr_d = r_ptr_q + {{DEPTH_SIZE{1'b0}}, rd_en};

  always_comb begin
    word_d      = word_q;
    out_valid_d = out_valid_q;
    phase_d     = phase_q;
    if (rd_en) begin
      word_d      = {mem_hi[r_addr], mem_lo[r_addr]};
      out_valid_d = 1'b1;
      phase_d     = PHASE_LO;
    end else if (handshake) begin
      if (phase_q == PHASE_LO) begin
        phase_d = PHASE_HI;
      end else begin
        out_valid_d = 1'b0;
        phase_d     = PHASE_LO;
      end
    end
  end

  // A read in the same cycle clears overflow even if a refused write sets it.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (rd_en) begin
      overflow_d = 1'b0;
    end else if (bus.wr & tick & full) begin
      overflow_d = 1'b1;
    end
    if (wr_en) begin
      underflow_d = 1'b0;
    end else if (bus.out_ready & ~out_valid_q) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_lo[w_addr] <= bus.data_in[OUTPUT_DATA_WIDTH-1:0];
      mem_hi[w_addr] <= bus.data_in[INPUT_DATA_WIDTH-1:OUTPUT_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q  <= '0;
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      phase_q     <= PHASE_LO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.data_out    = (phase_q == PHASE_HI) ?
                           {{PAD_WIDTH{1'b0}}, word_q[INPUT_DATA_WIDTH-1:OUTPUT_DATA_WIDTH]} :
                           word_q[OUTPUT_DATA_WIDTH-1:0];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_valid_q & phase_q;
  assign bus.wr_en_100ns = wr_en;
  assign bus.data_count  = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.threshold   = count[DEPTH_SIZE] | count[DEPTH_SIZE-1];
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_datapath_unpack_fifo.sv
// Directed bench for datapath_unpack_fifo: a CLK_DIV=5 full-depth instance and
// a CLK_DIV=1 16-deep instance, each with a beat scoreboard on its output.
module tb_datapath_unpack_fifo;

  localparam int CLK_DIV_A = 5;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;
  int   beatCountA;

  logic [128:0] qA [$];
  logic [128:0] qB [$];

  logic         prevStallA, prevStallB;
  logic [127:0] prevDataA, prevDataB;
  logic         prevLastA, prevLastB;

  datapath_unpack_fifo_if #(.DEPTH_SIZE(10)) busA ();
  datapath_unpack_fifo_if #(.DEPTH_SIZE(4))  busB ();

  datapath_unpack_fifo #(.DEPTH(1024), .DEPTH_SIZE(10), .CLK_DIV(CLK_DIV_A)) dutA (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busA.slave)
  );

  datapath_unpack_fifo #(.DEPTH(16), .DEPTH_SIZE(4), .CLK_DIV(1)) dutB (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [191:0] makeWord(input int i);
    return {16'hB0B0, i[15:0], i * 3, 96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, i};
  endfunction

  task automatic pushA(input logic [191:0] w);
    qA.push_back({1'b0, w[127:0]});
    qA.push_back({1'b1, 64'h0, w[191:128]});
  endtask

  task automatic pushB(input logic [191:0] w);
    qB.push_back({1'b0, w[127:0]});
    qB.push_back({1'b1, 64'h0, w[191:128]});
  endtask

  // Hold wr until the paced write port accepts the word, then drop it.
  task automatic applyStimulus(input logic [191:0] w, output bit accepted);
    @(posedge clk);
    #1;
    busA.wr      = 1'b1;
    busA.data_in = w;
    accepted     = 1'b0;
    for (int c = 0; c < CLK_DIV_A + 2 && !accepted; c++) begin
      @(negedge clk);
      if (busA.wr_en_100ns) begin
        accepted = 1'b1;
        pushA(w);
      end
    end
    @(posedge clk);
    #1;
    busA.wr = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 192'(busA.out_valid), 192'(0));
    checkOutput({tag, "_data"}, 192'(busA.data_out), 192'(0));
    checkOutput({tag, "_last"}, 192'(busA.out_last), 192'(0));
    checkOutput({tag, "_wren"}, 192'(busA.wr_en_100ns), 192'(0));
    checkOutput({tag, "_full"}, 192'(busA.full), 192'(0));
    checkOutput({tag, "_empty"}, 192'(busA.empty), 192'(1));
    checkOutput({tag, "_count"}, 192'(busA.data_count), 192'(0));
    checkOutput({tag, "_thresh"}, 192'(busA.threshold), 192'(0));
    checkOutput({tag, "_ovf"}, 192'(busA.overflow), 192'(0));
    checkOutput({tag, "_udf"}, 192'(busA.underflow), 192'(0));
  endtask

  // Scoreboard and stall-stability monitor for instance A.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      prevStallA = 1'b0;
    end else begin
      if (prevStallA) begin
        checkOutput("stall_data_A", 192'(busA.data_out), 192'(prevDataA));
        checkOutput("stall_last_A", 192'(busA.out_last), 192'(prevLastA));
      end
      if (busA.out_valid && busA.out_ready) begin
        beatCountA++;
        checkOutput("beat_expected_A", 192'(qA.size() != 0), 192'(1));
        if (qA.size() != 0)
          checkOutput("beat_A", 192'({busA.out_last, busA.data_out}), 192'(qA.pop_front()));
      end
      prevStallA = busA.out_valid & ~busA.out_ready;
      prevDataA  = busA.data_out;
      prevLastA  = busA.out_last;
    end
  end

  // Scoreboard and stall-stability monitor for instance B.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      prevStallB = 1'b0;
    end else begin
      if (prevStallB) begin
        checkOutput("stall_data_B", 192'(busB.data_out), 192'(prevDataB));
        checkOutput("stall_last_B", 192'(busB.out_last), 192'(prevLastB));
      end
      if (busB.out_valid && busB.out_ready) begin
        checkOutput("beat_expected_B", 192'(qB.size() != 0), 192'(1));
        if (qB.size() != 0)
          checkOutput("beat_B", 192'({busB.out_last, busB.data_out}), 192'(qB.pop_front()));
      end
      prevStallB = busB.out_valid & ~busB.out_ready;
      prevDataB  = busB.data_out;
      prevLastB  = busB.out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [191:0] w;
    bit           acc;
    int           firstTick;
    int           accB;
    int           remaining;
    int           idx;
    int           beatsBefore;

    errors = 0;
    checks = 0;
    beatCountA = 0;
    rstn = 1'b0;
    busA.wr = 1'b0; busA.data_in = '0; busA.out_ready = 1'b0;
    busB.wr = 1'b0; busB.data_in = '0; busB.out_ready = 1'b0;

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");

    $display("[TB] single word, first tick and latency");
    w = {{16{4'hA}}, {32{4'h5}}};
    @(posedge clk);
    #1;
    rstn = 1'b1;
    busA.wr = 1'b1; busA.data_in = w; busA.out_ready = 1'b1;
    firstTick = 0;
    for (int c = 1; c <= 4 * CLK_DIV_A && firstTick == 0; c++) begin
      @(negedge clk);
      if (busA.wr_en_100ns) firstTick = c;
    end
    checkOutput("first_tick", 192'(firstTick), 192'(CLK_DIV_A));
    pushA(w);
    @(posedge clk);
    #1;
    busA.wr = 1'b0;
    @(negedge clk);
    checkOutput("lat_valid_e0", 192'(busA.out_valid), 192'(0));
    checkOutput("lat_empty_e0", 192'(busA.empty), 192'(0));
    checkOutput("wren_single_pulse", 192'(busA.wr_en_100ns), 192'(0));
    @(negedge clk);
    checkOutput("lat_valid_e1", 192'(busA.out_valid), 192'(1));
    checkOutput("beat0_last", 192'(busA.out_last), 192'(0));
    checkOutput("beat0_data", 192'(busA.data_out), 192'(w[127:0]));
    @(negedge clk);
    checkOutput("beat1_last", 192'(busA.out_last), 192'(1));
    checkOutput("beat1_data", 192'(busA.data_out), 192'({64'h0, w[191:128]}));
    @(negedge clk);
    checkOutput("after_valid", 192'(busA.out_valid), 192'(0));
    checkOutput("after_empty", 192'(busA.empty), 192'(1));

    $display("[TB] fill to full with out_ready low");
    @(posedge clk);
    #1;
    busA.out_ready = 1'b0;
    for (int k = 0; k <= 1024; k++) begin
      applyStimulus(makeWord(k), acc);
      checkOutput("fill_accept", 192'(acc), 192'(1));
      @(negedge clk);
      @(negedge clk);
      checkOutput("fill_count", 192'(busA.data_count), 192'(k));
      checkOutput("fill_thresh", 192'(busA.threshold), 192'(k >= 512));
      checkOutput("fill_full", 192'(busA.full), 192'(k == 1024));
    end

    $display("[TB] write while full");
    @(posedge clk);
    #1;
    busA.wr = 1'b1;
    busA.data_in = makeWord(9999);
    idx = 0;
    for (int c = 0; c < CLK_DIV_A + 2; c++) begin
      @(negedge clk);
      if (busA.wr_en_100ns) idx++;
    end
    @(posedge clk);
    #1;
    busA.wr = 1'b0;
    @(negedge clk);
    checkOutput("full_refused", 192'(idx), 192'(0));
    checkOutput("full_overflow", 192'(busA.overflow), 192'(1));
    checkOutput("full_count", 192'(busA.data_count), 192'(1024));

    $display("[TB] drain from full");
    @(posedge clk);
    #1;
    busA.out_ready = 1'b1;
    beatsBefore = beatCountA;
    repeat (2050) @(negedge clk);
    #1;
    checkOutput("drain_no_bubble", 192'(beatCountA - beatsBefore), 192'(2050));
    checkOutput("drain_ovf_clear", 192'(busA.overflow), 192'(0));
    @(negedge clk);
    checkOutput("drain_valid", 192'(busA.out_valid), 192'(0));
    checkOutput("drain_empty", 192'(busA.empty), 192'(1));
    checkOutput("drain_queue", 192'(qA.size()), 192'(0));

    $display("[TB] random stall");
    remaining = 24;
    idx = 0;
    for (int c = 0; c < 3000 && (remaining > 0 || qA.size() != 0); c++) begin
      @(posedge clk);
      #1;
      busA.out_ready = 1'($urandom_range(0, 1));
      busA.wr = (remaining > 0);
      busA.data_in = makeWord(5000 + idx);
      @(negedge clk);
      if (busA.wr_en_100ns) begin
        pushA(makeWord(5000 + idx));
        idx++;
        remaining--;
      end
    end
    @(posedge clk);
    #1;
    busA.wr = 1'b0;
    busA.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("stall_all_written", 192'(remaining), 192'(0));
    checkOutput("stall_queue", 192'(qA.size()), 192'(0));

    $display("[TB] underflow");
    checkOutput("udf_set", 192'(busA.underflow), 192'(1));
    applyStimulus(makeWord(7000), acc);
    checkOutput("udf_accept", 192'(acc), 192'(1));
    @(negedge clk);
    checkOutput("udf_clear", 192'(busA.underflow), 192'(0));
    repeat (4) @(negedge clk);
    checkOutput("udf_queue", 192'(qA.size()), 192'(0));

    $display("[TB] reset mid-stream");
    @(posedge clk);
    #1;
    busA.out_ready = 1'b0;
    applyStimulus(makeWord(7100), acc);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    busA.out_ready = 1'b1;
    @(posedge clk);
    #1;
    busA.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("mid_last", 192'(busA.out_last), 192'(1));
    #2;
    rstn = 1'b0;
    #1;
    checkResetValues("midreset");
    qA.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    w = makeWord(7200);
    applyStimulus(w, acc);
    checkOutput("post_accept", 192'(acc), 192'(1));
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_valid", 192'(busA.out_valid), 192'(1));
    checkOutput("post_last", 192'(busA.out_last), 192'(0));
    checkOutput("post_data", 192'(busA.data_out), 192'(w[127:0]));
    @(posedge clk);
    #1;
    busA.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_queue", 192'(qA.size()), 192'(0));

    $display("[TB] CLK_DIV=1 fill");
    accB = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      busB.wr = 1'b1;
      busB.data_in = makeWord(1000 + accB);
      @(negedge clk);
      if (busB.wr_en_100ns) begin
        pushB(makeWord(1000 + accB));
        accB++;
      end
    end
    @(posedge clk);
    #1;
    busB.wr = 1'b0;
    @(negedge clk);
    checkOutput("B_accepted", 192'(accB), 192'(17));
    checkOutput("B_full", 192'(busB.full), 192'(1));
    checkOutput("B_count", 192'(busB.data_count), 192'(16));
    checkOutput("B_overflow", 192'(busB.overflow), 192'(1));

    @(posedge clk);
    #1;
    busB.out_ready = 1'b1;
    for (int c = 0; c < 100 && qB.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("B_drain_queue", 192'(qB.size()), 192'(0));
    checkOutput("B_drain_empty", 192'(busB.empty), 192'(1));

    $display("[TB] CLK_DIV=1 simultaneous read and write");
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      busB.wr = 1'b1;
      busB.data_in = makeWord(2000 + k);
      @(negedge clk);
      checkOutput("B_simul_count", 192'(busB.data_count), 192'((k + 1) / 2));
      checkOutput("B_simul_wren", 192'(busB.wr_en_100ns), 192'(1));
      if (busB.wr_en_100ns) pushB(makeWord(2000 + k));
    end
    @(posedge clk);
    #1;
    busB.wr = 1'b0;
    for (int c = 0; c < 100 && qB.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("B_final_queue", 192'(qB.size()), 192'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
